// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of one single-port synchronous RAM.
// Each access takes four cycles: grant, RAM command, read capture, done pulse.
module mem_arbiter #(
    parameter int STREAK_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_done_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  streak;
    logic        any_req;
    logic        pick_if;
    logic        grant_if;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [3:0]  lat_sel;
    logic [31:0] lat_wdata;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

    assign any_req = if_req_i | mem_req_i;
    // Data wins ties until it has won STREAK_MAX times in a row against a waiting fetch.
    assign pick_if = if_req_i & (~mem_req_i | (int'(streak) == STREAK_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command is frozen at grant so requesters cannot disturb an access in flight.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && any_req) begin
            grant_if  <= pick_if;
            lat_addr  <= pick_if ? if_addr_i : mem_addr_i;
            lat_we    <= pick_if ? 1'b0 : mem_we_i;
            lat_sel   <= pick_if ? 4'b1111 : mem_sel_i;
            lat_wdata <= pick_if ? 32'd0 : mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= 2'd0;
        end else if (state == IDLE && any_req) begin
            if (pick_if || !if_req_i) begin
                streak <= 2'd0;
            end else begin
                streak <= sat_inc(streak);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_data_o  <= 32'd0;
            mem_data_o <= 32'd0;
        end else if (state == CAPTURE && !lat_we) begin
            if (grant_if) begin
                if_data_o <= ram_data_i;
            end else begin
                mem_data_o <= ram_data_i;
            end
        end
    end

    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = 32'd0;
        ram_sel_o  = 4'd0;
        ram_data_o = 32'd0;
        if_done_o  = 1'b0;
        mem_done_o = 1'b0;
        busy_o     = (state != IDLE);
        case (state)
            ACCESS: begin
                ram_ce_o   = 1'b1;
                ram_we_o   = lat_we;
                ram_addr_o = lat_addr;
                ram_sel_o  = lat_sel;
                ram_data_o = lat_wdata;
            end
            DONE: begin
                if_done_o  = grant_if;
                mem_done_o = ~grant_if;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all checked each cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int STREAK = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_done_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;
    logic        busy_o;

    mem_arbiter #(.STREAK_MAX(STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_done_o(mem_done_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
        .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0000_0013;
        return 32'hA500_0000 | (32'(i) * 32'h0001_0101);
    endfunction

    // RAM environment: 16 words indexed by address bits [5:2], one-cycle read latency.
    logic [31:0] ram_q [16];
    logic [15:0] written = 16'd0;

    function automatic logic [31:0] rd_word(input logic [3:0] idx);
        return written[idx] ? ram_q[idx] : init_word(int'(idx));
    endfunction

    always @(posedge clk) begin : ram_model
        logic [31:0] w;
        if (ram_ce_o) begin
            if (ram_we_o) begin
                w = rd_word(ram_addr_o[5:2]);
                for (int b = 0; b < 4; b++)
                    if (ram_sel_o[b]) w[8*b +: 8] = ram_data_o[8*b +: 8];
                ram_q[ram_addr_o[5:2]]   <= w;
                written[ram_addr_o[5:2]] <= 1'b1;
            end else begin
                ram_data_i <= rd_word(ram_addr_o[5:2]);
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: phase counts cycles since grant (0 = no access in flight).
    int          m_t = 0;
    int          m_streak = 0;
    logic        m_if = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [3:0]  m_sel = 4'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] exp_if_data = 32'd0;
    logic [31:0] exp_mem_data = 32'd0;
    logic        after_rst = 1'b1;
    logic [31:0] m_mem [16];

    bit    rand_on = 1'b0;
    bit    log_on = 1'b0;
    string glog = "";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic gi;
        logic [31:0] w;
        if (rst) begin
            m_t = 0;
            m_streak = 0;
            exp_if_data = 32'd0;
            exp_mem_data = 32'd0;
            after_rst = 1'b1;
            return;
        end
        after_rst = 1'b0;
        if (m_t == 0) begin
            if (if_req_i || mem_req_i) begin
                gi = if_req_i && (!mem_req_i || m_streak == STREAK);
                if (gi || !if_req_i) m_streak = 0;
                else m_streak = (m_streak < 3) ? m_streak + 1 : 3;
                m_if    = gi;
                m_we    = gi ? 1'b0 : mem_we_i;
                m_addr  = gi ? if_addr_i : mem_addr_i;
                m_sel   = gi ? 4'hF : mem_sel_i;
                m_wdata = gi ? 32'd0 : mem_data_i;
                if (m_we) begin
                    w = m_mem[m_addr[5:2]];
                    for (int b = 0; b < 4; b++)
                        if (m_sel[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                    m_mem[m_addr[5:2]] = w;
                end else begin
                    m_rdata = m_mem[m_addr[5:2]];
                end
                m_t = 1;
            end
        end else if (m_t == 3) begin
            m_t = 0;
        end else begin
            m_t = m_t + 1;
            if (m_t == 3 && !m_we) begin
                if (m_if) exp_if_data = m_rdata;
                else exp_mem_data = m_rdata;
            end
        end
    endtask

    task automatic check_outputs();
        chk1("busy", busy_o, m_t != 0);
        chk1("ram_ce", ram_ce_o, m_t == 1);
        chk1("ram_we", ram_we_o, (m_t == 1) && m_we);
        if (m_t == 1) begin
            chk("ram_addr", ram_addr_o, m_addr);
            chk("ram_sel", {28'd0, ram_sel_o}, {28'd0, m_sel});
            chk("ram_wdata", ram_data_o, m_wdata);
        end
        if (after_rst) begin
            chk("rst_ram_addr", ram_addr_o, 32'd0);
            chk("rst_ram_sel", {28'd0, ram_sel_o}, 32'd0);
            chk("rst_ram_wdata", ram_data_o, 32'd0);
        end
        chk1("if_done", if_done_o, (m_t == 3) && m_if);
        chk1("mem_done", mem_done_o, (m_t == 3) && !m_if);
        chk("if_data", if_data_o, exp_if_data);
        chk("mem_data", mem_data_o, exp_mem_data);
        if (log_on && if_done_o) glog = {glog, "F"};
        if (log_on && mem_done_o) glog = {glog, "D"};
    endtask

    task automatic drive_random();
        if (rst) rst = 1'b0;
        else if ($urandom_range(0, 49) == 0) rst = 1'b1;
        if (!if_req_i || if_done_o) begin
            if_req_i  = ($urandom_range(0, 2) != 0);
            if_addr_i = $urandom();
        end
        if (!mem_req_i || mem_done_o) begin
            mem_req_i  = ($urandom_range(0, 2) != 0);
            mem_we_i   = $urandom_range(0, 1) == 1;
            mem_addr_i = $urandom();
            mem_sel_i  = 4'($urandom_range(0, 15));
            mem_data_i = $urandom();
        end
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge,
    // then return just after the edge so directed code can drive and sample.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (rand_on) drive_random();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && busy_o; k++) tick();
        chk1("drain_idle", busy_o, 1'b0);
    endtask

    task automatic wait_if_done(input string name);
        for (int k = 0; k < 16 && !if_done_o; k++) tick();
        chk1(name, if_done_o, 1'b1);
    endtask

    task automatic wait_mem_done(input string name);
        for (int k = 0; k < 16 && !mem_done_o; k++) tick();
        chk1(name, mem_done_o, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_ce_we"}, {30'd0, ram_ce_o, ram_we_o}, 32'd0);
        chk({tag, "_dones"}, {30'd0, if_done_o, mem_done_o}, 32'd0);
        chk({tag, "_if_data"}, if_data_o, 32'd0);
        chk({tag, "_mem_data"}, mem_data_o, 32'd0);
        chk({tag, "_ram_addr"}, ram_addr_o, 32'd0);
        chk({tag, "_ram_sel_data"}, ram_data_o | {28'd0, ram_sel_o}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = init_word(i);
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = 32'd0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_sel_i = 4'd0; mem_data_i = 32'd0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Fetch only from 0x10 holding 0x13.
        if_req_i = 1'b1; if_addr_i = 32'h10;
        tick();
        chk1("f_ce", ram_ce_o, 1'b1);
        chk("f_sel", {28'd0, ram_sel_o}, 32'hF);
        chk1("f_we", ram_we_o, 1'b0);
        chk("f_addr", ram_addr_o, 32'h10);
        tick();
        chk1("f_ce_off", ram_ce_o, 1'b0);
        tick();
        chk1("f_done", if_done_o, 1'b1);
        chk("f_data", if_data_o, 32'h13);
        if_req_i = 1'b0;
        tick();
        chk1("f_done_once", if_done_o, 1'b0);
        drain();

        // Reset while a fetch is in CAPTURE, then refetch.
        if_req_i = 1'b1; if_addr_i = 32'h10;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("rst_capture");
        rst = 1'b0;
        wait_if_done("refetch_done");
        chk("refetch_data", if_data_o, 32'h13);
        if_req_i = 1'b0;
        drain();

        // Byte-lane write, then read it back.
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h100; mem_sel_i = 4'b0011; mem_data_i = 32'hAABBCCDD;
        tick();
        chk1("w_we", ram_we_o, 1'b1);
        chk("w_addr", ram_addr_o, 32'h100);
        chk("w_sel", {28'd0, ram_sel_o}, 32'h3);
        chk("w_data", ram_data_o, 32'hAABBCCDD);
        tick();
        chk1("w_we_once", ram_we_o, 1'b0);
        tick();
        chk1("w_done", mem_done_o, 1'b1);
        chk("w_mem_data_kept", mem_data_o, 32'd0);
        mem_req_i = 1'b0;
        drain();
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF;
        wait_mem_done("rb_done");
        chk("rb_data", mem_data_o, 32'hA500CCDD);
        mem_req_i = 1'b0;
        drain();

        // Address changed while the access is in flight.
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h24; mem_sel_i = 4'hF;
        tick();
        mem_addr_i = 32'h30;
        chk("latched_addr", ram_addr_o, 32'h24);
        wait_mem_done("latched_done");
        chk("latched_data", mem_data_o, 32'hA5090909);
        mem_req_i = 1'b0;
        drain();

        // Both ports held continuously: streak limit decides the order.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h24; mem_sel_i = 4'hF;
        log_on = 1'b1;
        for (int k = 0; k < 60 && glog.len() < 8; k++) tick();
        log_on = 1'b0;
        n_vec++;
        if (glog != "DDDFDDDF") begin
            n_err++;
            $display("FAIL grant_order: got %s, expected DDDFDDDF", glog);
        end
        if_req_i = 1'b0; mem_req_i = 1'b0;
        drain();

        // Randomized traffic with occasional resets.
        rand_on = 1'b1;
        repeat (3000) tick();
        rand_on = 1'b0;
        rst = 1'b0; if_req_i = 1'b0; mem_req_i = 1'b0;
        tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STREAK_MAX, default 3: maximum consecutive data-port grants while a fetch request is pending.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port if_req_i, input, 1 bit: instruction-fetch request.
REQ-005 SHALL have port if_addr_i, input, 32 bits: fetch byte address.
REQ-006 SHALL have port if_data_o, output, 32 bits: fetched word, registered.
REQ-007 SHALL have port if_done_o, output, 1 bit: one-cycle fetch-completion pulse.
REQ-008 SHALL have port mem_req_i, input, 1 bit: data-access request.
REQ-009 SHALL have port mem_we_i, input, 1 bit: data access is a write.
REQ-010 SHALL have port mem_addr_i, input, 32 bits: data byte address.
REQ-011 SHALL have port mem_sel_i, input, 4 bits: byte lane enables.
REQ-012 SHALL have port mem_data_i, input, 32 bits: write data.
REQ-013 SHALL have port mem_data_o, output, 32 bits: read data, registered.
REQ-014 SHALL have port mem_done_o, output, 1 bit: one-cycle data-completion pulse.
REQ-015 SHALL have ports ram_ce_o (1), ram_we_o (1), ram_addr_o (32), ram_sel_o (4), ram_data_o (32), all outputs: single-port synchronous RAM command.
REQ-016 SHALL have port ram_data_i, input, 32 bits: RAM read data, valid the cycle after the ram_ce_o cycle.
REQ-017 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.

Function
REQ-018 SHALL implement the FSM IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE, one cycle per non-IDLE state.
REQ-019 SHALL stay in IDLE while both requests are low; on any request it SHALL grant one port, latch its command and go to ACCESS.
REQ-020 SHALL grant the data port over the fetch port when both are requested, except as in REQ-021.
REQ-021 SHALL hold a 2-bit saturating streak counter: +1 per data grant made while if_req_i is high; when counter == STREAK_MAX and both request, the fetch port is granted; counter cleared on every fetch grant and when if_req_i is low at a grant.
REQ-022 In ACCESS, SHALL drive ram_ce_o=1, ram_addr_o=latched address, ram_we_o=latched we (0 for fetch), ram_sel_o=latched sel (4'b1111 for fetch), ram_data_o=latched write data (0 for fetch).
REQ-023 Outside ACCESS, SHALL drive ram_ce_o=0 and ram_we_o=0; ram_addr_o, ram_sel_o and ram_data_o are don't-care.
REQ-024 In CAPTURE, SHALL register ram_data_i into the granted port's data output for reads; writes leave both data outputs unchanged.
REQ-025 In DONE, SHALL assert exactly one of if_done_o and mem_done_o for one cycle; the data output SHALL hold its value until the next read completes on that port.
REQ-026 Latency: request sampled in IDLE at edge E0 -> ram_ce_o high between E0 and E1 -> done high between E2 and E3; throughput is one access per 4 cycles.
REQ-027 Requesters SHALL hold req, addr, we, sel and data stable until done; the command SHALL be latched at grant, so later changes do not affect the access in flight.
REQ-028 A request still high in the IDLE cycle after DONE SHALL be treated as a new access.
REQ-029 The ungranted request SHALL wait with no done pulse and no loss; it is arbitrated at the next IDLE.
REQ-030 Addresses SHALL pass unmodified; no alignment checking.

Reset
REQ-031 rst high at a rising edge SHALL force IDLE, clear the streak counter and drive if_data_o=0, mem_data_o=0, if_done_o=0, mem_done_o=0, ram_ce_o=0, ram_we_o=0, ram_sel_o=0, ram_addr_o=0, ram_data_o=0 and busy_o=0.
REQ-032 rst during ACCESS, CAPTURE or DONE SHALL abandon the access with no done pulse; a write already presented in ACCESS is not retracted.
REQ-033 Requests high during rst SHALL be ignored; arbitration resumes in the first cycle after rst is low.

Verification
REQ-034 Fetch only: if_req_i=1, if_addr_i=0x10, RAM word 0x00000013 -> one ram_ce_o cycle with sel=4'hF and we=0; if_done_o pulses 3 cycles after sampling with if_data_o=0x00000013.
REQ-035 Data write: mem_we_i=1, addr=0x100, sel=4'b0011, data=0xAABBCCDD -> ram_we_o=1 for one cycle with those values; mem_done_o pulses once; mem_data_o unchanged.
REQ-036 Simultaneous requests: both held continuously with STREAK_MAX=3 -> grant order D,D,D,F,D,D,D,F; no done pulse without its grant.
REQ-037 Reset in CAPTURE of a fetch -> no if_done_o, all outputs 0 next cycle; fetch re-requested after reset completes normally.
REQ-038 Command changed after grant: mem_addr_i changed during ACCESS -> ram_addr_o keeps the originally latched address.
